// File: rtl/pe_result_wb_if.sv
// Write-back bus from pe_result_wb to the output neuron memory.
// One write transfers on every cycle where wr_valid && wr_ready.
interface pe_result_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/pe_result_wb.sv
// PE result write-back: optional ReLU, small FIFO, sequential writes
// to output memory, job completion pulse and sticky protocol errors.
module pe_result_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [15:0]       cfg_num,
    input  logic              cfg_relu,
    input  logic [DATA_W-1:0] pe_result,
    input  logic              pe_vld,
    pe_result_wb_if.master    wb,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_extra
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       num_q, num_d;
    logic              relu_q, relu_d;
    logic [15:0]       in_cnt_q, in_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_extra_q, err_extra_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;

    logic              empty;
    logic              full;
    logic              wr_valid;
    logic              pop;
    logic              push_req;
    logic              push;
    logic [DATA_W-1:0] push_data;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign wr_valid = (state_q == S_RUN) && !empty;
    assign pop      = wr_valid && wb.wr_ready;
    assign push_req = (state_q == S_RUN) && pe_vld && (in_cnt_q < num_q);
    // A full FIFO still accepts a result when the head leaves this cycle.
    assign push     = push_req && (!full || pop);
    assign push_data = (relu_q && pe_result[DATA_W-1]) ? '0 : pe_result;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        relu_d      = relu_q;
        in_cnt_d    = in_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        err_ovf_d   = err_ovf_q;
        err_extra_d = err_extra_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            wr_cnt_d = wr_cnt_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = cfg_base;
                    num_d       = cfg_num;
                    relu_d      = cfg_relu;
                    in_cnt_d    = '0;
                    wr_cnt_d    = '0;
                    err_ovf_d   = 1'b0;
                    err_extra_d = 1'b0;
                    state_d     = (cfg_num == 16'd0) ? S_DONE : S_RUN;
                end else if (pe_vld) begin
                    err_extra_d = 1'b1;
                end
            end
            S_RUN: begin
                if (pe_vld) begin
                    if (in_cnt_q < num_q) begin
                        // Counted even when dropped so the job still ends.
                        in_cnt_d = in_cnt_q + 16'd1;
                        if (!push) begin
                            err_ovf_d = 1'b1;
                        end
                    end else begin
                        err_extra_d = 1'b1;
                    end
                end
                if ((in_cnt_d == num_q) && (count_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (pe_vld) begin
                    err_extra_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            relu_q      <= 1'b0;
            in_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            err_ovf_q   <= 1'b0;
            err_extra_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            relu_q      <= relu_d;
            in_cnt_q    <= in_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_extra_q <= err_extra_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign wb.wr_valid = wr_valid;
    assign wb.wr_addr  = base_q + ADDR_W'(wr_cnt_q);
    assign wb.wr_data  = mem_q[rd_ptr_q];
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign err_ovf     = err_ovf_q;
    assign err_extra   = err_extra_q;
endmodule
